// File: rtl/fifo_sync_if.sv
// Push/full write port and pop/empty read port of the synchronous FIFO.
// The producer and consumer use the master modport; the FIFO uses the slave modport.
interface fifo_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] up_data;
  logic                  up_push;
  logic                  up_full;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output up_data, up_push, fifo_pop,
    input  up_full, fifo_data, fifo_empty, count
  );

  modport slave (
    input  up_data, up_push, fifo_pop,
    output up_full, fifo_data, fifo_empty, count
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data; fifo_data updates one cycle after an accepted pop.
// All flags are registered. A push while full is dropped, and a pop while empty is ignored.
module fifo_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_sync_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en, rd_en;

  // Enables are gated by the registered flags, so there is no input-to-output path.
  always_comb begin
    wr_en    = bus.up_push & ~full_q & ~rst;
    rd_en    = bus.fifo_pop & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
    // The pointer difference, modulo 2^(ADDR_WIDTH+1), is the occupancy, 0..DEPTH.
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.up_data;
    end
  end

  assign bus.up_full    = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_data  = data_q;
  assign bus.count      = count_q;
endmodule
